// File: rtl/riscy_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, RAM size
// encodings, the sequencer state type and a funct3 -> access size helper.
package riscy_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_LCAP   = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_t;

   // For every legal code the low two funct3 bits are the log2 byte count.
   function automatic logic [1:0] f3_size(input logic [2:0] f3);
      return f3[1:0];
   endfunction

   // Byte count minus one; illegal size 3 maps to 7 and is rejected anyway.
   function automatic logic [2:0] size_span(input logic [1:0] sz);
      logic [2:0] s;
      case (sz)
         SZ_B:    s = 3'd0;
         SZ_H:    s = 3'd1;
         SZ_W:    s = 3'd3;
         default: s = 3'd7;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load result extension: sign-extends B/H, zero-extends BU/HU, passes W.
import riscy_pkg::*;

module load_ext (
   input  logic [31:0] asm_data,
   input  logic [2:0]  funct3,
   output logic [31:0] ext_data
);

   // Pick the extension rule from funct3.
   always_comb begin
      ext_data = asm_data;
      case (funct3)
         F3_LB:   ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
         F3_LH:   ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
         F3_LBU:  ext_data = {24'b0, asm_data[7:0]};
         F3_LHU:  ext_data = {16'b0, asm_data[15:0]};
         default: ext_data = asm_data;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time, drives the RAM data port,
// splits misaligned accesses into byte beats and reassembles loads.
import riscy_pkg::*;

module lsu #(
   parameter int ADDR_W         = 14,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] d_addr,
   output logic [31:0]       d_in,
   output logic [1:0]        d_size,
   output logic              w_en,
   output logic              u_en,
   input  logic [31:0]       d_out
);

   lsu_state_t        state;
   logic              st_store;
   logic [2:0]        st_f3;
   logic [ADDR_W-1:0] st_base;
   logic [31:0]       st_wdata;
   logic              st_split;
   logic              st_err;
   logic [1:0]        beat;
   logic [1:0]        beat_last;
   logic [31:0]       asm_q;
   logic [31:0]       ext_data;

   // acceptance-time decode of the incoming request
   logic [1:0]  acc_size;
   logic        acc_f3_ok;
   logic        acc_misal;
   logic        acc_range_bad;
   logic        acc_err;
   logic [1:0]  acc_last;
   logic [32:0] acc_end;

   // next-beat address/data for split sequencing
   logic [1:0]        beat_nxt;
   logic [ADDR_W-1:0] nxt_addr;
   logic [31:0]       nxt_din;
   logic              last_beat;

   // Classify the request: legality, alignment, range and beat count.
   always_comb begin
      acc_size  = f3_size(req_funct3);
      acc_f3_ok = (req_funct3 == F3_LB) || (req_funct3 == F3_LH) ||
                  (req_funct3 == F3_LW) || (req_funct3 == F3_LBU) ||
                  (req_funct3 == F3_LHU);
      acc_misal = ((acc_size == SZ_H) && req_addr[0]) ||
                  ((acc_size == SZ_W) && (req_addr[1:0] != 2'b00));
      // Last byte touched must stay inside the RAM; a 33-bit sum catches
      // both nonzero upper address bits and wrap past the top.
      acc_end       = {1'b0, req_addr} + {30'b0, size_span(acc_size)};
      acc_range_bad = |acc_end[32:ADDR_W];
      acc_err = !acc_f3_ok ||
                (req_store && req_funct3[2]) ||
                acc_range_bad ||
                (acc_misal && !MISALIGN_SPLIT);
      acc_last = 2'd0;
      if (acc_misal)
         acc_last = (acc_size == SZ_W) ? 2'd3 : 2'd1;
   end

   // Address and store data for the following beat.
   always_comb begin
      beat_nxt  = beat + 2'd1;
      nxt_addr  = st_base + ADDR_W'(beat_nxt);
      nxt_din   = st_split ? (st_wdata >> {beat_nxt, 3'b000}) : st_wdata;
      last_beat = (beat == beat_last);
   end

   // Access sequencer: accept, issue beats, capture read data, respond.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         st_store  <= 1'b0;
         st_f3     <= 3'b0;
         st_base   <= '0;
         st_wdata  <= 32'b0;
         st_split  <= 1'b0;
         st_err    <= 1'b0;
         beat      <= 2'd0;
         beat_last <= 2'd0;
         asm_q     <= 32'b0;
         d_addr    <= '0;
         d_in      <= 32'b0;
         d_size    <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  st_store  <= req_store;
                  st_f3     <= req_funct3;
                  st_base   <= req_addr[ADDR_W-1:0];
                  st_wdata  <= req_wdata;
                  st_split  <= acc_misal;
                  st_err    <= acc_err;
                  beat      <= 2'd0;
                  beat_last <= acc_last;
                  asm_q     <= 32'b0;
                  if (acc_err) begin
                     // rejected requests never reach the RAM port
                     state <= ST_RESP;
                  end else begin
                     state  <= ST_ACCESS;
                     d_addr <= req_addr[ADDR_W-1:0];
                     d_in   <= req_wdata;
                     d_size <= acc_misal ? SZ_B : acc_size;
                  end
               end
            end
            ST_ACCESS: begin
               if (!st_store) begin
                  state <= ST_LCAP;
               end else if (last_beat) begin
                  state <= ST_RESP;
               end else begin
                  beat   <= beat_nxt;
                  d_addr <= nxt_addr;
                  d_in   <= nxt_din;
               end
            end
            ST_LCAP: begin
               if (st_split)
                  asm_q[{beat, 3'b000} +: 8] <= d_out[7:0];
               else
                  asm_q <= d_out;
               if (last_beat) begin
                  state <= ST_RESP;
               end else begin
                  state  <= ST_ACCESS;
                  beat   <= beat_nxt;
                  d_addr <= nxt_addr;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   load_ext u_ext (
      .asm_data (asm_q),
      .funct3   (st_f3),
      .ext_data (ext_data)
   );

   // Handshake, strobe and response outputs decoded straight from state,
   // so w_en can only ever be high in ACCESS.
   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      resp_err   = resp_valid && st_err;
      w_en       = (state == ST_ACCESS) && st_store;
      u_en       = 1'b1;
      resp_rdata = (resp_valid && !st_store && !st_err) ? ext_data : 32'b0;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: byte RAM model, vector table, hand sequences
// for reset abort, back-to-back issue and the no-split configuration.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
   logic        req_ready, resp_valid, resp_err, w_en, u_en;
   logic [31:0] resp_rdata, d_in, d_out;
   logic [13:0] d_addr;
   logic [1:0]  d_size;

   logic        r0_valid = 1'b0, r0_store = 1'b0;
   logic [2:0]  r0_f3 = 3'b0;
   logic [31:0] r0_addr = 32'b0, r0_wdata = 32'b0;
   logic        rdy0, rv0, re0, we0, ue0;
   logic [31:0] rd0, di0;
   logic [31:0] d_out0 = 32'b0;
   logic [13:0] da0;
   logic [1:0]  ds0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [16384];
   logic [13:0] ba [4];
   logic [7:0]  bd [4];

   always #5 clk = ~clk;

   lsu #(.ADDR_W(14), .MISALIGN_SPLIT(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .d_addr(d_addr), .d_in(d_in), .d_size(d_size),
      .w_en(w_en), .u_en(u_en), .d_out(d_out)
   );

   lsu #(.ADDR_W(14), .MISALIGN_SPLIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(rdy0),
      .req_store(r0_store), .req_funct3(r0_f3), .req_addr(r0_addr),
      .req_wdata(r0_wdata), .resp_valid(rv0), .resp_rdata(rd0),
      .resp_err(re0), .d_addr(da0), .d_in(di0), .d_size(ds0),
      .w_en(we0), .u_en(ue0), .d_out(d_out0)
   );

   // RAM model: byte-addressed, registered read zero-extended (u_en=1).
   always @(posedge clk) begin
      case (d_size)
         2'd0:    d_out <= {24'b0, mem[d_addr]};
         2'd1:    d_out <= {16'b0, mem[d_addr+14'd1], mem[d_addr]};
         default: d_out <= {mem[d_addr+14'd3], mem[d_addr+14'd2],
                             mem[d_addr+14'd1], mem[d_addr]};
      endcase
      if (w_en) begin
         mem[d_addr] <= d_in[7:0];
         if (d_size != 2'd0) mem[d_addr+14'd1] <= d_in[15:8];
         if (d_size == 2'd2) begin
            mem[d_addr+14'd2] <= d_in[23:16];
            mem[d_addr+14'd3] <= d_in[31:24];
         end
      end
   end

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
      end
   endtask

   // Issue one request and wait for its response, recording write beats.
   task automatic run(input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int wens, output logic [1:0] sz0);
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; wens = 0; sz0 = 2'd0;
      do begin
         @(negedge clk);
         lat++;
         if (w_en) begin
            if (wens < 4) begin
               ba[wens] = d_addr;
               bd[wens] = d_in[7:0];
            end
            if (wens == 0) sz0 = d_size;
            wens++;
         end
      end while (!resp_valid && lat < 40);
      rd = resp_rdata;
      er = resp_err;
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          wens;
      logic [1:0]  sz;
      logic        beats;
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, wens, seen;
      logic [1:0]  sz0;

      vt[0]  = '{1'b1, 3'b010, 32'h10,       32'hdeadbeef, 32'h0,        1'b0, 2, 1, 2'd2, 1'b0};
      vt[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hdeadbeef, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[2]  = '{1'b1, 3'b000, 32'h21,       32'h00000080, 32'h0,        1'b0, 2, 1, 2'd0, 1'b0};
      vt[3]  = '{1'b0, 3'b000, 32'h21,       32'h0,        32'hffffff80, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[4]  = '{1'b0, 3'b100, 32'h21,       32'h0,        32'h00000080, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[5]  = '{1'b1, 3'b010, 32'h3,        32'h11223344, 32'h0,        1'b0, 5, 4, 2'd0, 1'b1};
      vt[6]  = '{1'b0, 3'b010, 32'h3,        32'h0,        32'h11223344, 1'b0, 9, 0, 2'd0, 1'b0};
      vt[7]  = '{1'b1, 3'b001, 32'h21,       32'h0000c3d4, 32'h0,        1'b0, 3, 2, 2'd0, 1'b1};
      vt[8]  = '{1'b0, 3'b001, 32'h21,       32'h0,        32'hffffc3d4, 1'b0, 5, 0, 2'd0, 1'b0};
      vt[9]  = '{1'b0, 3'b101, 32'h21,       32'h0,        32'h0000c3d4, 1'b0, 5, 0, 2'd0, 1'b0};
      vt[10] = '{1'b1, 3'b010, 32'h3ffc,     32'hcafef00d, 32'h0,        1'b0, 2, 1, 2'd2, 1'b0};
      vt[11] = '{1'b0, 3'b000, 32'h3fff,     32'h0,        32'hffffffca, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[12] = '{1'b0, 3'b010, 32'h3ffe,     32'h0,        32'h0,        1'b1, 1, 0, 2'd0, 1'b0};
      vt[13] = '{1'b0, 3'b001, 32'h3fff,     32'h0,        32'h0,        1'b1, 1, 0, 2'd0, 1'b0};
      vt[14] = '{1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 2'd0, 1'b0};
      vt[15] = '{1'b1, 3'b100, 32'h10,       32'h55,       32'h0,        1'b1, 1, 0, 2'd0, 1'b0};
      vt[16] = '{1'b0, 3'b010, 32'h00010010, 32'h0,        32'h0,        1'b1, 1, 0, 2'd0, 1'b0};
      vt[17] = '{1'b0, 3'b010, 32'h3ffc,     32'h0,        32'hcafef00d, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[18] = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hdeadbeef, 1'b0, 3, 0, 2'd0, 1'b0};
      vt[19] = '{1'b0, 3'b101, 32'h3ffe,     32'h0,        32'h0000cafe, 1'b0, 3, 0, 2'd0, 1'b0};

      // reset state, both instances
      #2;
      chk("rst_ready", 0, {31'b0, req_ready}, 32'd1);
      chk("rst_resp", 0, {29'b0, resp_valid, resp_err, w_en}, 32'd0);
      chk("rst_rdata", 0, resp_rdata, 32'd0);
      chk("rst_port", 0, {16'b0, d_addr, d_size}, 32'd0);
      chk("rst_din", 0, d_in, 32'd0);
      chk("rst_uen", 0, {30'b0, u_en, ue0}, 32'd3);
      chk("rst_ready0", 0, {31'b0, rdy0}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat, wens, sz0);
         chk("rdata", i, rd, vt[i].rdata);
         chk("err", i, {31'b0, er}, {31'b0, vt[i].err});
         chk("latency", i, 32'(lat), 32'(vt[i].lat));
         chk("wen_count", i, 32'(wens), 32'(vt[i].wens));
         if (vt[i].wens > 0)
            chk("size", i, {30'b0, sz0}, {30'b0, vt[i].sz});
         if (vt[i].beats)
            for (int j = 0; j < vt[i].wens; j++) begin
               chk("beat_addr", j, {18'b0, ba[j]}, vt[i].addr + 32'(j));
               chk("beat_data", j, {24'b0, bd[j]}, (vt[i].wdata >> (8*j)) & 32'hff);
            end
         @(negedge clk);
         chk("one_pulse", i, {30'b0, resp_valid, req_ready}, 32'd1);
      end

      // reset during second beat of a split store
      run(1'b1, 3'b010, 32'h40, 32'h0, rd, er, lat, wens, sz0);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h41; req_wdata = 32'ha1b2c3d4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("beat2_wen", 0, {31'b0, w_en}, 32'd1);
      chk("beat2_addr", 0, {18'b0, d_addr}, 32'h42);
      rst = 1'b1;
      #1;
      chk("abort_ready", 0, {31'b0, req_ready}, 32'd1);
      chk("abort_resp", 0, {29'b0, resp_valid, resp_err, w_en}, 32'd0);
      chk("abort_port", 0, {16'b0, d_addr, d_size}, 32'd0);
      chk("abort_din", 0, d_in | resp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      chk("abort_noresp", 0, 32'(seen), 32'd0);
      run(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wens, sz0);
      chk("abort_mem", 0, rd, 32'h0000d400);
      chk("abort_lat", 0, 32'(lat), 32'd3);

      // back-to-back with req_valid held
      run(1'b1, 3'b010, 32'h0, 32'h80017fff, rd, er, lat, wens, sz0);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
      @(posedge clk);
      #1 req_funct3 = 3'b001; req_addr = 32'h2;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("b2b_busy", k, {31'b0, req_ready}, 32'd0);
      end
      chk("b2b_resp1", 0, {31'b0, resp_valid}, 32'd1);
      chk("b2b_rdata1", 0, resp_rdata, 32'h80017fff);
      @(negedge clk);
      chk("b2b_ready", 0, {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 40);
      chk("b2b_lat2", 0, 32'(lat), 32'd3);
      chk("b2b_rdata2", 0, resp_rdata, 32'hffff8001);

      // no-split configuration: misaligned half is an error, aligned is not
      @(negedge clk);
      r0_valid = 1'b1; r0_store = 1'b1; r0_f3 = 3'b001;
      r0_addr = 32'h1; r0_wdata = 32'h1234;
      @(posedge clk);
      #1 r0_valid = 1'b0;
      @(negedge clk);
      chk("ns_err", 0, {29'b0, rv0, re0, we0}, 32'd6);
      chk("ns_rdata", 0, rd0, 32'd0);
      @(negedge clk);
      r0_addr = 32'h2; r0_valid = 1'b1;
      @(posedge clk);
      #1 r0_valid = 1'b0;
      @(negedge clk);
      chk("ns_wen", 0, {31'b0, we0}, 32'd1);
      chk("ns_port", 0, {16'b0, da0, ds0}, {16'b0, 14'h2, 2'd1});
      chk("ns_din", 0, di0, 32'h1234);
      @(negedge clk);
      chk("ns_resp", 0, {30'b0, rv0, re0}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
